// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI master arbiter.
//   DATA_W  : frame width, fixed to match the SPI slave (12 bits).
//   BIT_W   : width of the in-frame bit counter.
//   PER_W   : width of the sclk-period counter.
//   state_t : master frame FSM states.
//   dbg_t   : debug view of the FSM and divider strobes.
package spi_pkg;

  localparam int DATA_W = 12;
  localparam int BIT_W  = 4;
  localparam int PER_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    WAIT_DONE,
    GAP
  } state_t;

  typedef struct packed {
    state_t             state;
    logic [BIT_W-1:0]   bitcnt;
    logic               rise_tick;
    logic               fall_tick;
  } dbg_t;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running SPI clock divider.
//   clk       : system clock.
//   rst       : asynchronous active-high reset (sclk=0, count=0).
//   sclk      : SPI clock, half-period CLK_DIV clk cycles.
//   rise_tick : 1-clk strobe in the cycle whose ending edge raises sclk.
//   fall_tick : 1-clk strobe in the cycle whose ending edge lowers sclk.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  // The strobes lead the sclk edge by one cycle so that registers updated
  // on a strobe change on the same clk edge that moves sclk.
  assign rise_tick = wrap & ~sclk;
  assign fall_tick = wrap &  sclk;

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter in front of a single 12-bit LSB-first SPI master.
//   clk, rst : system clock, asynchronous active-high reset.
//   req      : per-requester request level.
//   din      : flattened words, requester i at din[i*DATA_W +: DATA_W].
//   gnt      : one-hot 1-clk pulse in the cycle the word is captured.
//   ack      : one-hot 1-clk pulse when the slave reports done.
//   err      : 1-clk pulse when done_in does not arrive within TO_PER periods.
//   busy     : high from gnt until the inter-frame gap ends.
//   sclk, cs, mosi : SPI link (cs active-low).
//   done_in  : slave done, sclk-synchronous, sampled directly on clk.
//   dbg      : FSM state, bit counter and divider strobes.
//
// Handshake: req is a level; a requester is served when it sees its gnt bit
// pulse, at which point its din word has been captured and req may drop.
// A requester left high while another is served waits for a later IDLE.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CLK_DIV = 4,
  parameter int TO_PER  = 4,
  parameter int GAP_PER = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic                    busy,
  output logic                    sclk,
  output logic                    cs,
  output logic                    mosi,
  input  logic                    done_in,
  output dbg_t                    dbg
);

  localparam int IDX_W = $clog2(N_REQ);

  logic rise_tick;
  logic fall_tick;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   winner, winner_n;
  logic [DATA_W-1:0]  word, word_n;
  logic [BIT_W-1:0]   bitcnt, bitcnt_n;
  logic [PER_W-1:0]   per_cnt, per_cnt_n;
  logic [N_REQ-1:0]   gnt_n, ack_n;
  logic               err_n, busy_n, cs_n, mosi_n;

  // Round-robin pick: first requester at or after ptr, wrapping.
  logic [IDX_W-1:0]   win_idx;
  always_comb begin : rr_pick
    int  j;
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[IDX_W'(j)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      winner  <= '0;
      word    <= '0;
      bitcnt  <= '0;
      per_cnt <= '0;
      gnt     <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      winner  <= winner_n;
      word    <= word_n;
      bitcnt  <= bitcnt_n;
      per_cnt <= per_cnt_n;
      gnt     <= gnt_n;
      ack     <= ack_n;
      err     <= err_n;
      busy    <= busy_n;
      cs      <= cs_n;
      mosi    <= mosi_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    winner_n  = winner;
    word_n    = word;
    bitcnt_n  = bitcnt;
    per_cnt_n = per_cnt;
    gnt_n     = '0;
    ack_n     = '0;
    err_n     = 1'b0;
    busy_n    = busy;
    cs_n      = cs;
    mosi_n    = mosi;

    case (state)
      IDLE: begin
        if (|req) begin
          winner_n       = win_idx;
          word_n         = din[win_idx*DATA_W +: DATA_W];
          gnt_n[win_idx] = 1'b1;
          ptr_n          = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          busy_n         = 1'b1;
          state_n        = LOAD;
        end
      end
      LOAD: begin
        if (fall_tick) begin
          cs_n    = 1'b0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        // One full sclk period with cs low and mosi idle lets the slave
        // enter its read state before bit 0 is presented.
        if (fall_tick) begin
          mosi_n   = word[0];
          bitcnt_n = '0;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          if (bitcnt < BIT_W'(DATA_W - 1)) begin
            bitcnt_n = bitcnt + 1'b1;
            mosi_n   = word[bitcnt + 1'b1];
          end else begin
            cs_n      = 1'b1;
            mosi_n    = 1'b0;
            per_cnt_n = '0;
            state_n   = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        // done_in is checked first so a done arriving on the timeout
        // strobe still acks instead of flagging an error.
        if (done_in) begin
          ack_n[winner] = 1'b1;
          per_cnt_n     = '0;
          state_n       = GAP;
        end else if (fall_tick) begin
          if (per_cnt == PER_W'(TO_PER - 1)) begin
            err_n     = 1'b1;
            per_cnt_n = '0;
            state_n   = GAP;
          end else begin
            per_cnt_n = per_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (fall_tick) begin
          if (per_cnt == PER_W'(GAP_PER - 1)) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            per_cnt_n = per_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign dbg.state     = state;
  assign dbg.bitcnt    = bitcnt;
  assign dbg.rise_tick = rise_tick;
  assign dbg.fall_tick = fall_tick;

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;
  import spi_pkg::*;

  localparam int N_REQ    = 4;
  localparam int CLK_DIV  = 4;
  localparam int TO_PER   = 4;
  localparam int GAP_PER  = 2;
  localparam int SCLK_PER = 2 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        gnt, ack;
  logic                    err, busy, sclk, cs, mosi, done_in;
  dbg_t                    dbg;

  spi_master_arbiter #(
    .N_REQ   (N_REQ),
    .CLK_DIV (CLK_DIV),
    .TO_PER  (TO_PER),
    .GAP_PER (GAP_PER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .sclk    (sclk),
    .cs      (cs),
    .mosi    (mosi),
    .done_in (done_in),
    .dbg     (dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] words[N_REQ];
  int model_ptr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Round-robin reference: first requesting index at or after p, wrapping.
  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // ---------------- SPI slave model ----------------
  logic              slave_en;
  logic              active;
  logic [4:0]        nbits;
  logic [DATA_W-1:0] sh, dout;

  always @(posedge sclk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      nbits   <= '0;
      done_in <= 1'b0;
      sh      <= '0;
      dout    <= '0;
    end else begin
      done_in <= 1'b0;
      if (!cs) begin
        if (!active) begin
          active <= 1'b1;
          nbits  <= '0;
        end else if (nbits < 5'(DATA_W)) begin
          sh[nbits[3:0]] <= mosi;
          nbits          <= nbits + 1'b1;
        end
      end else if (active) begin
        active <= 1'b0;
        if (nbits == 5'(DATA_W)) begin
          dout    <= sh;
          done_in <= slave_en;
        end
      end
    end
  end

  // ---------------- background monitors ----------------
  int cyc = 0;
  int cs_rise_cyc = 0;
  bit rise_valid = 1'b0;
  logic cs_q = 1'b1;
  int ack_seen = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (ack != '0) ack_seen++;
    if (err) err_seen++;
    if (rst) begin
      rise_valid = 1'b0;
      cs_q       = 1'b1;
    end else begin
      if (cs && !cs_q) begin
        cs_rise_cyc = cyc;
        rise_valid  = 1'b1;
      end
      if (!cs && cs_q && rise_valid)
        check("cs_high_gap", 32'((cyc - cs_rise_cyc) >= (GAP_PER + 1) * SCLK_PER), 1);
      cs_q = cs;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_din();
    for (int i = 0; i < N_REQ; i++) din[i*DATA_W +: DATA_W] = words[i];
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    exp_q.delete();
  endtask

  // One complete frame: grant, serial transfer, ack or timeout, gap.
  task automatic run_frame(input logic [N_REQ-1:0] pat, input bit want_ack);
    int   exp_w;
    int   n;
    bit   seen;
    logic [DATA_W-1:0] exp_word;
    exp_w    = rr_pick(pat, model_ptr);
    slave_en = want_ack;
    drive_din();
    req      = pat;

    seen = 1'b0;
    n    = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (gnt != '0);
    end
    check("gnt_seen", 32'(seen), 1);
    if (!seen) return;
    check("gnt_onehot", 32'(gnt), 32'(1 << exp_w));
    check("busy_at_gnt", 32'(busy), 1);
    exp_q.push_back(words[exp_w]);
    model_ptr = (exp_w + 1) % N_REQ;

    // Served requester drops; din is scrambled to prove it was latched.
    req = req & ~gnt;
    for (int i = 0; i < N_REQ; i++) din[i*DATA_W +: DATA_W] = DATA_W'($urandom);

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * SCLK_PER) begin
      @(negedge clk);
      n++;
      if (n == 1) check("gnt_pulse", 32'(gnt), 0);
      seen = !cs;
    end
    check("cs_fall_latency", 32'(seen && n >= 1 && n <= SCLK_PER), 1);
    if (!seen) return;

    n = 1;
    while (!cs && n < 200) begin
      @(negedge clk);
      if (!cs) n++;
    end
    check("cs_low_len", 32'(n), 32'(13 * SCLK_PER));

    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = (ack != '0) || err;
    end
    check("resp_seen", 32'(seen), 1);
    if (want_ack) begin
      check("ack_onehot", 32'(ack), 32'(1 << exp_w));
      check("no_err", 32'(err), 0);
      check("ack_latency", 32'(n <= SCLK_PER + 2), 1);
    end else begin
      check("err_pulse", 32'(err), 1);
      check("no_ack", 32'(ack), 0);
      check("err_latency", 32'(n), 32'(TO_PER * SCLK_PER));
    end
    exp_word = exp_q.pop_front();
    check("slave_dout", 32'(dout), 32'(exp_word));

    @(negedge clk);
    check("resp_pulse", 32'({ack, err}), 0);

    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall", 32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    int   ack0, err0;
    logic [N_REQ-1:0] pat;
    req      = '0;
    din      = '0;
    slave_en = 1'b1;
    for (int i = 0; i < N_REQ; i++) words[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_cs", 32'(cs), 1);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_gnt_ack", 32'({gnt, ack}), 0);
    check("rst_err_busy", 32'({err, busy}), 0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    rst = 1'b0;

    // Single frame.
    words[0] = 12'hA5C;
    run_frame(4'b0001, 1'b1);

    // Round-robin order from a fresh pointer.
    pulse_reset();
    words[0] = 12'h001; words[1] = 12'h002; words[2] = 12'h004; words[3] = 12'h008;
    run_frame(4'b1111, 1'b1);
    run_frame(req, 1'b1);
    run_frame(req, 1'b1);
    run_frame(req, 1'b1);

    // Pointer wrap: move ptr to 2, then 1 and 3 together.
    run_frame(4'b0010, 1'b1);
    run_frame(4'b1010, 1'b1);
    run_frame(req, 1'b1);

    // Timeout followed by a normal frame.
    for (int i = 0; i < N_REQ; i++) words[i] = DATA_W'($urandom);
    run_frame(4'(1 << $urandom_range(0, N_REQ - 1)), 1'b0);
    run_frame(4'(1 << $urandom_range(0, N_REQ - 1)), 1'b1);

    // Reset in the middle of a frame.
    for (int i = 0; i < N_REQ; i++) words[i] = DATA_W'($urandom);
    slave_en = 1'b1;
    drive_din();
    req = 4'b0001;
    n = 0;
    while (gnt == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_gnt_seen", 32'(gnt != '0), 1);
    req = '0;
    n = 0;
    while (!(active && nbits >= 5'd6) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_bit5_reached", 32'(active && nbits >= 5'd6), 1);
    ack0 = ack_seen;
    err0 = err_seen;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cs", 32'(cs), 1);
    check("mid_rst_mosi", 32'(mosi), 0);
    check("mid_rst_outs", 32'({sclk, gnt, ack, err, busy}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    exp_q.delete();
    repeat (150) @(negedge clk);
    check("mid_no_resp", 32'((ack_seen - ack0) + (err_seen - err0)), 0);
    words[2] = 12'hFFF;
    run_frame(4'b0100, 1'b1);

    // Randomized frames against the round-robin model.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N_REQ; i++) words[i] = DATA_W'($urandom);
      pat = 4'($urandom_range(1, (1 << N_REQ) - 1));
      run_frame(pat, ($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Shares one 12-bit SPI link among `N_REQ` requesters. The block arbitrates round-robin, latches the winning word, and drives `sclk`/`cs`/`mosi` in the frame format the team's SPI slave expects: CS low for one setup period, then 12 bits LSB-first. It then waits for the slave's `done` and returns a per-requester ack or an error pulse. It sits between the host-side requesters and the SPI slave in the testbench top and the system.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 12: frame width; fixed to match the slave.
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles (≥2); `sclk` period = 2·`CLK_DIV` clk.
- `TO_PER`, 4: `sclk` periods to wait for `done_in` before flagging an error.
- `GAP_PER`, 2: minimum `sclk` periods with `cs` high between frames (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N_REQ  request level per requester.
- `din`  in  N_REQ·DATA_W  flattened words; requester i uses `din[i*DATA_W +: DATA_W]`.
- `gnt`  out  N_REQ  one-hot, 1-clk pulse when the word is captured.
- `ack`  out  N_REQ  one-hot, 1-clk pulse when the slave confirms the frame.
- `err`  out  1  1-clk pulse on `done_in` timeout.
- `busy`  out  1  high from `gnt` until the `GAP` state ends.
- `sclk`  out  1  free-running SPI clock (slave `sync_clock`).
- `cs`  out  1  chip select, active-low.
- `mosi`  out  1  serial data.
- `done_in`  in  1  slave `done`; synchronous to `sclk`, so it is sampled directly in `clk`.

## Operation
- **Clock divider.** `sclk` runs continuously after reset. It produces `rise_tick`/`fall_tick` strobes, each a 1-clk strobe in the clk cycle where `sclk` toggles. `cs`/`mosi` change only on `fall_tick`; the slave samples on the rising edge.
- **Arbiter.** Round-robin. Search starts at pointer `ptr`. After a grant, `ptr` = winner+1 mod `N_REQ`. Reset sets `ptr` = 0. Only requesters with `req` high at the sample cycle are eligible.
- **State machine:**
  - `IDLE`: if any `req` is set, latch the winner index and word, pulse `gnt`, go to `LOAD`.
  - `LOAD`: on `fall_tick` set `cs`=0 and go to `SETUP`.
  - `SETUP`: on `fall_tick` set `mosi`=word[0], set `bitcnt`=0, go to `SHIFT`.
  - `SHIFT`: on `fall_tick`:
    - if `bitcnt`<11: `bitcnt`++ and `mosi`=word[`bitcnt`+1];
    - else: `cs`=1, `mosi`=0, clear the timeout counter, go to `WAIT_DONE`.
  - `WAIT_DONE`: evaluated in this order:
    - if `done_in`=1, pulse `ack[winner]` and go to `GAP`;
    - else count `fall_tick`; when the count reaches `TO_PER`, pulse `err` and go to `GAP`.
  - `GAP`: count `GAP_PER` `fall_tick`s with `cs`=1, then go to `IDLE`.
- `req` dropping after `gnt` has no effect; the frame completes. `req` held while another requester is served waits for a later `IDLE`.
- `din` is sampled only in the `gnt` cycle.
- `done_in` is ignored outside `WAIT_DONE`.

## Timing
- **Reset values:** `sclk`=0, `cs`=1, `mosi`=0, `gnt`=`ack`=0, `err`=0, `busy`=0, `ptr`=0; state `IDLE`; divider count 0.
- **Reset mid-frame:** `cs` goes high and all outputs take their reset values immediately (asynchronous). No `ack`/`err` is issued for the aborted frame.
- **`req` to `gnt`:** 1 clk (registered). `gnt` to `cs` low: 1..2·`CLK_DIV` clk, up to the next `fall_tick`.
- **`cs` low duration:** exactly 13 `sclk` periods (1 setup + 12 bits).
- **Slave behaviour:** it enters read on the first rising edge with `cs` low and samples bits 0..11 on the next 12 rising edges. `done` rises on the rising edge after `cs` returns high, so `ack` follows `cs` rise by about 1 `sclk` period.
- **Minimum frame-to-frame spacing:** `cs` high ≥ `GAP_PER`+1 `sclk` periods. This guarantees the slave is back in its start state.
- **Simultaneous `done_in` and timeout in the same cycle:** `ack` wins and `err` is not pulsed.

## Structure
- **Package `spi_pkg`:** `DATA_W`=12 constant, the state enum {`IDLE`, `LOAD`, `SETUP`, `SHIFT`, `WAIT_DONE`, `GAP`}, and the widths of `bitcnt` and the timeout counter.
- **Sub-module `spi_clk_div`:** produces `sclk`, `rise_tick`, `fall_tick`; parameter `CLK_DIV`; async active-high `rst`.
- Arbiter and FSM live in the top module.

## Test plan
All scenarios use `CLK_DIV`=4, `TO_PER`=4, and the team's SPI slave attached.

1. **Single frame:** `req[0]`, `din0`=12'hA5C -> `gnt[0]` 1 clk later; `cs` low for exactly 104 clk; slave `dout`=12'hA5C; `ack[0]` pulse; `busy` falls after the gap.
2. **Round-robin order:** all four `req` high with words 12'h001/12'h002/12'h004/12'h008 -> grants in order 0,1,2,3; slave receives each word; `cs` high ≥3 `sclk` periods between frames.
3. **Pointer wrap:** with `ptr`=2, assert `req[1]` and `req[3]` together -> `gnt[3]` first, then `gnt[1]`.
4. **Timeout:** `done_in` tied to 0 -> `err` pulses 4 `sclk` periods after `cs` rises; no `ack`; next request is served normally.
5. **Reset mid-frame:** `rst` pulsed after bit 5 -> `cs`=1 and `mosi`=0 in the same cycle; no `ack`/`err`. A following `req[2]` frame with 12'hFFF completes with `dout`=12'hFFF.
6. **`req` drop after grant:** deassert `req[1]` immediately after `gnt[1]` -> frame still completes and `ack[1]` pulses.
